// File: rtl/prog_mem.sv
// prog_mem: writeable instruction memory for the C0 core.
// After reset the array is swept to FILL_WORD, then the fetch stage gets a
// registered read port and a valid/ready load port can write a program.
module prog_mem #(
  parameter int                DATA_W    = 21,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] FILL_WORD = 21'h1C0009
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH_EN,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              INSTR_VALID,
  input  logic              LD_START,
  input  logic [ADDR_W-1:0] LD_BASE,
  input  logic [ADDR_W:0]   LD_COUNT,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_VALID,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic              BUSY
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_rem;
  logic [DATA_W-1:0]   r_instr;
  logic                r_ivalid;
  logic                r_ld_ready;
  logic                r_ld_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_ld_fire;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                w_addr_ok;
  logic [DATA_W-1:0]   w_rd;
  logic [ADDR_W-1:0]   w_base_mod;

  assign w_ld_fire  = (r_state == S_LOAD) && LD_VALID && r_ld_ready;
  // Pointer wraps at DEPTH-1 so non-power-of-two depths also wrap correctly.
  assign w_ptr_nxt  = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  assign w_addr_ok  = ({1'b0, ADDR} < DEPTH_X);
  assign w_rd       = r_mem[ADDR];
  assign w_base_mod = ADDR_W'(32'(LD_BASE) % DEPTH);

  // Single write port shared by the clear sweep and the load stream.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = FILL_WORD;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_wdata = FILL_WORD;
    end else if (w_ld_fire) begin
      w_we    = 1'b1;
      w_wdata = LD_DATA;
    end
  end

  // Storage array: no reset, the clear sweep initialises it.
  always_ff @(posedge CLK) begin
    if (w_we) r_mem[r_ptr] <= w_wdata;
  end

  // Control FSM with registered fetch data and handshake outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_instr    <= FILL_WORD;
      r_ivalid   <= 1'b0;
      r_ld_ready <= 1'b0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ivalid  <= 1'b0;
      r_ld_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_ptr <= w_ptr_nxt;
          if (r_ptr == LAST) r_state <= S_IDLE;
        end
        S_IDLE: begin
          // Fetch and load start may coincide: the read is serviced now.
          if (FETCH_EN) begin
            r_instr  <= w_addr_ok ? w_rd : FILL_WORD;
            r_ivalid <= 1'b1;
          end
          if (LD_START) begin
            if (LD_COUNT == '0) begin
              r_ld_done <= 1'b1;
            end else begin
              r_ptr      <= w_base_mod;
              r_rem      <= LD_COUNT;
              r_state    <= S_LOAD;
              r_ld_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_ld_fire) begin
            r_ptr <= w_ptr_nxt;
            r_rem <= r_rem - 1'b1;
            if (r_rem == (ADDR_W+1)'(1)) begin
              r_state    <= S_IDLE;
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_CLEAR;
          r_ptr      <= '0;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  assign INSTRUCTION = r_instr;
  assign INSTR_VALID = r_ivalid;
  assign LD_READY    = r_ld_ready;
  assign LD_DONE     = r_ld_done;
  assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed tables, hand sequences for the
// multi-cycle corners and random loads/fetches against an array model.
module tb_prog_mem;
  localparam int          DW   = 21;
  localparam int          AW   = 8;
  localparam int          DEP  = 256;
  localparam logic [20:0] FILL = 21'h1C0009;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          FETCH_EN;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] INSTRUCTION;
  logic          INSTR_VALID;
  logic          LD_START;
  logic [AW-1:0] LD_BASE;
  logic [AW:0]   LD_COUNT;
  logic [DW-1:0] LD_DATA;
  logic          LD_VALID;
  logic          LD_READY;
  logic          LD_DONE;
  logic          BUSY;

  prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .FILL_WORD(FILL)) dut (
    .CLK(CLK), .RESET(RESET), .FETCH_EN(FETCH_EN), .ADDR(ADDR),
    .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .LD_START(LD_START), .LD_BASE(LD_BASE), .LD_COUNT(LD_COUNT),
    .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
    .LD_DONE(LD_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [DEP];
  logic [DW-1:0] ld_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait out the clear sweep, counting BUSY cycles and watching for stray pulses.
  task automatic wait_clear(output int n, output bit saw_v, output bit saw_d);
    n = 0; saw_v = 0; saw_d = 0;
    FETCH_EN = 1'b1; ADDR = 8'h03; LD_START = 1'b1; LD_COUNT = 9'd1;
    while (BUSY && n < 1000) begin
      tick();
      n++;
      saw_v |= INSTR_VALID;
      saw_d |= LD_DONE;
    end
    FETCH_EN = 1'b0; LD_START = 1'b0; LD_COUNT = '0;
    for (int i = 0; i < DEP; i++) model[i] = FILL;
  endtask

  task automatic fetch(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    FETCH_EN = 1'b1; ADDR = a;
    tick();
    FETCH_EN = 1'b0;
    chk({nm, "_valid"}, 32'(INSTR_VALID), 32'd1);
    chk({nm, "_data"}, 32'(INSTRUCTION), 32'(exp));
  endtask

  // Stream ld_q into an already-started load; model updated with wrap.
  task automatic feed(input int base, input int cnt, input int gap_at, input bit rnd);
    int early = 0;
    for (int i = 0; i < cnt; i++) begin
      if (i == gap_at || (rnd && $urandom_range(0, 2) == 0)) begin
        LD_VALID = 1'b0;
        tick();
        early += int'(LD_DONE);
      end
      LD_VALID = 1'b1; LD_DATA = ld_q[i];
      tick();
      model[(base + i) % DEP] = ld_q[i];
      if (i < cnt - 1) early += int'(LD_DONE);
    end
    LD_VALID = 1'b0;
    chk("ld_done_last", 32'(LD_DONE), 32'd1);
    chk("ld_done_early", 32'(early), 32'd0);
    chk("ld_busy_end", 32'(BUSY), 32'd0);
    chk("ld_ready_end", 32'(LD_READY), 32'd0);
    tick();
    chk("ld_done_once", 32'(LD_DONE), 32'd0);
  endtask

  task automatic do_load(input int base, input int cnt, input int gap_at, input bit rnd);
    LD_START = 1'b1; LD_BASE = AW'(base); LD_COUNT = (AW+1)'(cnt);
    chk("ld_ready_pre", 32'(LD_READY), 32'd0);
    tick();
    LD_START = 1'b0;
    if (cnt == 0) begin
      chk("zc_done", 32'(LD_DONE), 32'd1);
      chk("zc_busy", 32'(BUSY), 32'd0);
      tick();
      chk("zc_done_drop", 32'(LD_DONE), 32'd0);
      chk("zc_busy2", 32'(BUSY), 32'd0);
      return;
    end
    chk("ld_ready_up", 32'(LD_READY), 32'd1);
    chk("ld_busy_up", 32'(BUSY), 32'd1);
    feed(base, cnt, gap_at, rnd);
  endtask

  rd_vec_t fill_tab [4];
  rd_vec_t rd_tab   [10];

  initial begin
    int n; bit sv, sd; int base, cnt;
    logic [DW-1:0] held;

    fill_tab[0] = '{8'h00, FILL}; fill_tab[1] = '{8'h7F, FILL};
    fill_tab[2] = '{8'hFF, FILL}; fill_tab[3] = '{8'h80, FILL};
    rd_tab[0] = '{8'h10, 21'h05C000}; rd_tab[1] = '{8'h11, 21'h0C01BD};
    rd_tab[2] = '{8'h12, 21'h180000}; rd_tab[3] = '{8'h13, FILL};
    rd_tab[4] = '{8'hFE, 21'h0AAAAA}; rd_tab[5] = '{8'hFF, 21'h0BBBBB};
    rd_tab[6] = '{8'h00, 21'h0CCCCC}; rd_tab[7] = '{8'h01, 21'h0DDDDD};
    rd_tab[8] = '{8'h02, FILL};       rd_tab[9] = '{8'hFD, FILL};

    RESET = 1'b1; FETCH_EN = 0; ADDR = 0; LD_START = 0; LD_BASE = 0;
    LD_COUNT = 0; LD_DATA = 0; LD_VALID = 0;
    #3;
    chk("rst_instr", 32'(INSTRUCTION), 32'(FILL));
    chk("rst_ivalid", 32'(INSTR_VALID), 32'd0);
    chk("rst_ready", 32'(LD_READY), 32'd0);
    chk("rst_done", 32'(LD_DONE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd1);
    tick();
    RESET = 1'b0;
    wait_clear(n, sv, sd);
    chk("clear_cycles", 32'(n), 32'd256);
    chk("clear_no_fetch", 32'(sv), 32'd0);
    chk("clear_no_done", 32'(sd), 32'd0);
    chk("clear_no_load", 32'(LD_READY), 32'd0);

    // Back-to-back fetches of the cleared array.
    for (int i = 0; i < 4; i++) begin
      FETCH_EN = 1'b1; ADDR = fill_tab[i].addr;
      tick();
      chk("fill_valid", 32'(INSTR_VALID), 32'd1);
      chk("fill_data", 32'(INSTRUCTION), 32'(fill_tab[i].exp));
    end
    FETCH_EN = 1'b0; ADDR = 8'h44;
    tick();
    chk("idle_valid_low", 32'(INSTR_VALID), 32'd0);
    chk("idle_hold", 32'(INSTRUCTION), 32'(FILL));

    // Load with one stall, then a wrapping load.
    ld_q = '{21'h05C000, 21'h0C01BD, 21'h180000};
    do_load(8'h10, 3, 1, 1'b0);
    ld_q = '{21'h0AAAAA, 21'h0BBBBB, 21'h0CCCCC, 21'h0DDDDD};
    do_load(8'hFE, 4, -1, 1'b0);
    foreach (rd_tab[i]) fetch("rd_tab", rd_tab[i].addr, rd_tab[i].exp);

    // Zero-count load leaves the array untouched.
    do_load(8'h10, 0, -1, 1'b0);
    fetch("zc_keep", 8'h10, 21'h05C000);

    // Fetch and load start together; fetch during LOAD is dropped.
    FETCH_EN = 1'b1; ADDR = 8'h05; LD_START = 1'b1; LD_BASE = 8'h05; LD_COUNT = 9'd2;
    chk("sim_ready_pre", 32'(LD_READY), 32'd0);
    tick();
    LD_START = 1'b0;
    chk("sim_valid", 32'(INSTR_VALID), 32'd1);
    chk("sim_old_word", 32'(INSTRUCTION), 32'(FILL));
    chk("sim_ready", 32'(LD_READY), 32'd1);
    held = INSTRUCTION;
    ADDR = 8'h10;
    tick();
    FETCH_EN = 1'b0;
    chk("load_fetch_drop", 32'(INSTR_VALID), 32'd0);
    chk("load_fetch_hold", 32'(INSTRUCTION), 32'(FILL));
    ld_q = '{21'h111111, 21'h022222};
    feed(5, 2, -1, 1'b0);
    fetch("sim_new5", 8'h05, 21'h111111);
    fetch("sim_new6", 8'h06, 21'h022222);

    // Random loads (some longer than DEPTH) and random fetches vs model.
    for (int k = 0; k < 6; k++) begin
      base = $urandom_range(0, 255);
      cnt  = (k == 2) ? 300 : (k == 4) ? 0 : $urandom_range(1, 40);
      ld_q = {};
      for (int i = 0; i < cnt; i++) ld_q.push_back(DW'($urandom));
      do_load(base, cnt, -1, 1'b1);
      for (int j = 0; j < 8; j++) begin
        ADDR = AW'($urandom_range(0, 255));
        fetch("rnd_fetch", ADDR, model[ADDR]);
      end
    end
    for (int a = 0; a < DEP; a++) fetch("sweep", AW'(a), model[a]);

    // Reset in the middle of a 5-word load.
    ld_q = '{21'h1F0001, 21'h1F0002, 21'h1F0003, 21'h1F0004, 21'h1F0005};
    LD_START = 1'b1; LD_BASE = 8'h40; LD_COUNT = 9'd5;
    tick();
    LD_START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      LD_VALID = 1'b1; LD_DATA = ld_q[i];
      tick();
    end
    RESET = 1'b1;
    #2;
    chk("mid_rst_busy", 32'(BUSY), 32'd1);
    chk("mid_rst_ready", 32'(LD_READY), 32'd0);
    chk("mid_rst_done", 32'(LD_DONE), 32'd0);
    tick();
    RESET = 1'b0;
    wait_clear(n, sv, sd);
    LD_VALID = 1'b0;
    chk("mid_clear_cycles", 32'(n), 32'd256);
    chk("mid_no_done", 32'(sd), 32'd0);
    fetch("mid_w0", 8'h40, FILL);
    fetch("mid_w1", 8'h41, FILL);
    fetch("mid_w2", 8'h10, FILL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
